// File: rtl/demo_de0_sys_data_format_adapter_packer.sv
// Avalon-ST symbol packer: gathers 8-bit symbols into SYMBOLS_PER_BEAT-wide words with sop/eop/empty framing.
// Optional error propagation is enabled by defining DFA_PACKER_ERROR_EN.
module demo_de0_sys_data_format_adapter_packer #(
   parameter int SYMBOL_WIDTH     = 8,
   parameter int SYMBOLS_PER_BEAT = 4,
   parameter int EMPTY_WIDTH      = 2
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic [SYMBOL_WIDTH-1:0]                  in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     in_startofpacket,
   input  logic                                     in_endofpacket,
`ifdef DFA_PACKER_ERROR_EN
   input  logic                                     in_error,
   output logic                                     out_error,
`endif
   output logic [SYMBOL_WIDTH*SYMBOLS_PER_BEAT-1:0] out_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_startofpacket,
   output logic                                     out_endofpacket,
   output logic [EMPTY_WIDTH-1:0]                   out_empty
);

   localparam int SW  = SYMBOL_WIDTH;
   localparam int SPB = SYMBOLS_PER_BEAT;
   localparam int DW  = SW * SPB;
   localparam int CW  = (SPB > 1) ? $clog2(SPB) : 1;

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t           state_reg;
   logic [CW-1:0]    count_reg;
   logic [SW-1:0]    acc_reg [SPB];
   logic             sop_seen_reg;
   logic             ready_en_reg;
   logic             out_valid_reg;
   logic [DW-1:0]    out_data_reg;
   logic             out_sop_reg;
   logic             out_eop_reg;
   logic [EMPTY_WIDTH-1:0] out_empty_reg;

   logic             accept;
   logic             restart;
   logic             take;
   logic             complete;
   logic [CW-1:0]    slot;
   logic [DW-1:0]    word_next;

   // ready_en_reg keeps in_ready low through reset and the edge that releases it.
   assign in_ready = ready_en_reg & (~out_valid_reg | out_ready);

   assign accept   = in_valid & in_ready;
   assign restart  = accept & in_startofpacket;
   assign take     = accept & (in_startofpacket | (state_reg == IN_PKT));
   assign slot     = restart ? '0 : count_reg;
   assign complete = take & (in_endofpacket | (slot == CW'(SPB - 1)));

   genvar gi;
   generate
      for (gi = 0; gi < SPB; gi++) begin : g_slot
         assign word_next[SW*(SPB-gi)-1 -: SW] =
            (CW'(gi) == slot) ? in_data :
            (CW'(gi) <  slot) ? acc_reg[gi] : '0;
      end
   endgenerate

`ifdef DFA_PACKER_ERROR_EN
   logic err_acc_reg;
   logic out_error_reg;
   logic err_next;

   assign err_next  = (restart ? 1'b0 : err_acc_reg) | in_error;
   assign out_error = out_error_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_acc_reg   <= 1'b0;
         out_error_reg <= 1'b0;
      end else if (complete) begin
         err_acc_reg   <= 1'b0;
         out_error_reg <= err_next;
      end else if (take) begin
         err_acc_reg   <= err_next;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         sop_seen_reg  <= 1'b0;
         ready_en_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sop_reg   <= 1'b0;
         out_eop_reg   <= 1'b0;
         out_empty_reg <= '0;
         for (int k = 0; k < SPB; k++) acc_reg[k] <= '0;
      end else begin
         ready_en_reg <= 1'b1;
         if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;

         if (complete) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= word_next;
            out_sop_reg   <= restart | sop_seen_reg;
            out_eop_reg   <= in_endofpacket;
            out_empty_reg <= in_endofpacket ? EMPTY_WIDTH'(SPB - 1 - int'(slot)) : '0;
            count_reg     <= '0;
            sop_seen_reg  <= 1'b0;
            state_reg     <= in_endofpacket ? IDLE : IN_PKT;
            for (int k = 0; k < SPB; k++) acc_reg[k] <= '0;
         end else if (take) begin
            // A restart discards any partial word left by a packet that lost its eop.
            for (int k = 0; k < SPB; k++) begin
               if (CW'(k) == slot)  acc_reg[k] <= in_data;
               else if (restart)    acc_reg[k] <= '0;
            end
            count_reg    <= slot + CW'(1);
            sop_seen_reg <= restart | sop_seen_reg;
            state_reg    <= IN_PKT;
         end
      end
   end

   assign out_valid         = out_valid_reg;
   assign out_data          = out_data_reg;
   assign out_startofpacket = out_sop_reg;
   assign out_endofpacket   = out_eop_reg;
   assign out_empty         = out_empty_reg;

endmodule

// File: tb/tb_demo_de0_sys_data_format_adapter_packer.sv
// Scoreboard bench for the symbol packer: a packet-level model predicts words, a monitor compares.
// Define DFA_PACKER_ERROR_EN to also exercise the error ports.
module tb_demo_de0_sys_data_format_adapter_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [1:0]  out_empty;
   logic        in_error;
   logic        out_error_w;
`ifdef DFA_PACKER_ERROR_EN
   logic        out_error;
   assign out_error_w = out_error;
`else
   assign out_error_w = 1'b0;
`endif

   logic man_ready, rnd_ready, rnd_val;
   assign out_ready = rnd_ready ? rnd_val : man_ready;

   always #5 clk = ~clk;

   demo_de0_sys_data_format_adapter_packer dut (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
`ifdef DFA_PACKER_ERROR_EN
      .in_error(in_error), .out_error(out_error),
`endif
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty)
   );

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic        e;
      logic [1:0]  em;
      logic        er;
   } word_t;

   word_t exp_q[$];
   word_t seen[$];
   int    checks = 0;
   int    errors = 0;
   logic  mon_en = 1'b0;

   // packet-level reference state
   logic [7:0] cur[$];
   logic       in_pkt = 1'b0;
   logic       first_word = 1'b0;
   logic       cur_err = 1'b0;
   logic       lat_pend = 1'b0;
   word_t      lat_word;
   logic       hold_prev = 1'b0;
   logic [35:0] hold_val;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_accept(input logic [7:0] d, input logic s, input logic e, input logic er);
      word_t w;
      if (s) begin
         cur.delete();
         in_pkt = 1'b1;
         first_word = 1'b1;
         cur_err = 1'b0;
      end else if (!in_pkt) begin
         return;
      end
      cur.push_back(d);
      cur_err = cur_err | er;
      if (cur.size() == 4 || e) begin
         w.d = 32'h0;
         for (int i = 0; i < cur.size(); i++) w.d = w.d | (32'(cur[i]) << (8 * (3 - i)));
         w.s  = first_word;
         w.e  = e;
         w.em = e ? 2'((4 - cur.size()) % 4) : 2'd0;
`ifdef DFA_PACKER_ERROR_EN
         w.er = cur_err;
`else
         w.er = 1'b0;
`endif
         exp_q.push_back(w);
         lat_pend = 1'b1;
         lat_word = w;
         first_word = 1'b0;
         cur_err = 1'b0;
         cur.delete();
         if (e) in_pkt = 1'b0;
      end
   endtask

   // monitor: samples on the falling edge, mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (lat_pend) begin
            chk("latency_valid", 64'(out_valid), 64'd1);
            chk("latency_data", 64'(out_data), 64'(lat_word.d));
            lat_pend = 1'b0;
         end
         if (hold_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_word", 64'({out_data, out_startofpacket, out_endofpacket, out_empty}), 64'(hold_val));
         end
         chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid && out_ready) begin
            word_t g, x;
            g.d = out_data; g.s = out_startofpacket; g.e = out_endofpacket;
            g.em = out_empty; g.er = out_error_w;
            seen.push_back(g);
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               x = exp_q.pop_front();
               chk("word_data", 64'(g.d), 64'(x.d));
               chk("word_flags", 64'({g.s, g.e, g.em, g.er}), 64'({x.s, x.e, x.em, x.er}));
            end
         end
         hold_prev = out_valid && !out_ready;
         hold_val  = {out_data, out_startofpacket, out_endofpacket, out_empty};
         if (in_valid && in_ready) model_accept(in_data, in_startofpacket, in_endofpacket, in_error);
      end
   end

   initial begin
      rnd_val = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rnd_val = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_sym(input logic [7:0] d, input logic s, input logic e, input logic er);
      int   n = 0;
      logic acc = 1'b0;
      in_data = d; in_startofpacket = s; in_endofpacket = e; in_error = er; in_valid = 1'b1;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 64'(n), 64'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rnd_ready = 1'b0;
      man_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_seen(input string nm, input int idx, input logic [31:0] d,
                           input logic s, input logic e, input logic [1:0] em);
      if (idx >= seen.size()) begin
         chk({nm, "_missing"}, 64'(seen.size()), 64'(idx + 1));
      end else begin
         chk({nm, "_data"}, 64'(seen[idx].d), 64'(d));
         chk({nm, "_flags"}, 64'({seen[idx].s, seen[idx].e, seen[idx].em}), 64'({s, e, em}));
      end
   endtask

   initial begin
      int base;
      reset_n = 1'b0; in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0;
      in_endofpacket = 1'b0; in_error = 1'b0; man_ready = 1'b0; rnd_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_out_word", 64'({out_data, out_startofpacket, out_endofpacket, out_empty}), 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      man_ready = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // full 8-symbol packet
      base = seen.size();
      for (int i = 1; i <= 8; i++) send_sym(8'(i), i == 1, i == 8, 1'b0);
      drain();
      chk_seen("full_w0", base, 32'h01020304, 1'b1, 1'b0, 2'd0);
      chk_seen("full_w1", base + 1, 32'h05060708, 1'b0, 1'b1, 2'd0);

      // partial eop word, then single-symbol packet
      base = seen.size();
      send_sym(8'hAA, 1'b1, 1'b0, 1'b0);
      send_sym(8'hBB, 1'b0, 1'b0, 1'b0);
      send_sym(8'hCC, 1'b0, 1'b1, 1'b0);
      send_sym(8'h5A, 1'b1, 1'b1, 1'b0);
      drain();
      chk_seen("partial", base, 32'hAABBCC00, 1'b1, 1'b1, 2'd1);
      chk_seen("single", base + 1, 32'h5A000000, 1'b1, 1'b1, 2'd3);

      // backpressure: sink stalled while 8 symbols are offered
      base = seen.size();
      man_ready = 1'b0;
      fork
         for (int i = 1; i <= 8; i++) send_sym(8'(8'h10 + i), i == 1, i == 8, 1'b0);
         begin
            repeat (20) @(posedge clk);
            #1 man_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", 64'(seen.size() - base), 64'd2);
      chk_seen("bp_w0", base, 32'h11121314, 1'b1, 1'b0, 2'd0);
      chk_seen("bp_w1", base + 1, 32'h15161718, 1'b0, 1'b1, 2'd0);

      // framing errors: stray symbols and a packet missing its eop
      base = seen.size();
      send_sym(8'h11, 1'b0, 1'b0, 1'b0);
      send_sym(8'h22, 1'b0, 1'b0, 1'b0);
      send_sym(8'h33, 1'b1, 1'b0, 1'b0);
      send_sym(8'h44, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_sym(8'(8'h55 + i), i == 0, i == 3, 1'b0);
      drain();
      chk("frame_count", 64'(seen.size() - base), 64'd1);
      chk_seen("frame", base, 32'h55565758, 1'b1, 1'b1, 2'd0);

`ifdef DFA_PACKER_ERROR_EN
      base = seen.size();
      for (int i = 1; i <= 8; i++) send_sym(8'(i), i == 1, i == 8, i == 2);
      drain();
      if (seen.size() >= base + 2) begin
         chk("err_w0", 64'(seen[base].er), 64'd1);
         chk("err_w1", 64'(seen[base + 1].er), 64'd0);
      end else begin
         chk("err_count", 64'(seen.size() - base), 64'd2);
      end
`endif

      // randomized traffic with random sink stalls
      rnd_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         send_sym(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         #0;
      end
      drain();
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
